cache_fill_ctrl: RTL
====================

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width in bits.
REQ-002 SHALL have parameter WORD_BYTES, default 2, bytes per memory word (power of 2).
REQ-003 SHALL have parameter BLOCK_WORDS, default 8, words per cache block (power of 2, >=2).
REQ-004 SHALL have parameter CWF, default 0, critical-word-first enable (1 = fill starts at the missed word).
REQ-005 SHALL have ports in this order: clk in 1 (single clock, rising edge); rst_n in 1 (synchronous, active-low reset).
REQ-006 SHALL have ports: miss_detected in 1, miss_address in ADDR_W, victim_dirty in 1, victim_address in ADDR_W.
REQ-007 SHALL have ports: fsm_busy out 1, mem_req out 1, mem_we out 1, memory_address out ADDR_W, mem_ready in 1, memory_data_valid in 1.
REQ-008 SHALL have ports: wb_word_idx out log2(BLOCK_WORDS), data_word_idx out log2(BLOCK_WORDS), write_data_array out 1, write_tag_array out 1, fill_done out 1.

Function
REQ-009 SHALL implement states IDLE, WB and FILL.
REQ-010 IDLE: on miss_detected=1, SHALL latch miss_address, victim_address and victim_dirty, then go to WB if victim_dirty=1, else go to FILL.
REQ-011 SHALL ignore miss_detected outside IDLE.
REQ-012 SHALL drive fsm_busy = (state != IDLE), so fsm_busy rises the cycle after the miss is sampled.
REQ-013 A request SHALL be accepted in a cycle where mem_req=1 and mem_ready=1; while mem_ready=0, memory_address, mem_we and the word index SHALL hold.
REQ-014 Block base address SHALL be the latched address with its low log2(WORD_BYTES*BLOCK_WORDS) bits cleared; word address = base | (idx << log2(WORD_BYTES)).
REQ-015 WB: SHALL assert mem_req=1 and mem_we=1, and issue victim word idx 0..BLOCK_WORDS-1 in order, one per accepted cycle; wb_word_idx = idx being written (cache data array read index).
REQ-016 On acceptance of the last WB word, SHALL go to FILL the next cycle.
REQ-017 FILL: SHALL assert mem_req=1, mem_we=0 until BLOCK_WORDS reads are accepted, then deassert mem_req while waiting for responses.
REQ-018 FILL read idx SHALL be (start + req_cnt) mod BLOCK_WORDS, where start = missed word index if CWF=1, else 0 (wrap-around).
REQ-019 Responses SHALL arrive in issue order; each memory_data_valid=1 in FILL SHALL pulse write_data_array with data_word_idx = (start + rsp_cnt) mod BLOCK_WORDS.
REQ-020 Response counting SHALL be independent of request issue; a valid in the same cycle as an acceptance SHALL count both.
REQ-021 On the BLOCK_WORDS-th valid, SHALL pulse write_tag_array and fill_done for one cycle, in the same cycle as the final write_data_array, and go to IDLE next cycle.
REQ-022 SHALL ignore memory_data_valid in IDLE and WB.
REQ-023 Counters SHALL be log2(BLOCK_WORDS)+1 bits wide so that the full count is representable without aliasing.

Reset
REQ-024 When rst_n=0 at a rising edge, SHALL enter IDLE, clear all counters and latches, and drive every output to 0 the next cycle; this SHALL apply mid-operation.
REQ-025 After a reset, SHALL NOT pulse write_tag_array for the aborted fill, and SHALL ignore late valids.

Structure
REQ-026 Shared package cache_pkg SHALL hold the state enum typedef (IDLE, WB, FILL) and the default parameter constants.
REQ-027 SHALL instantiate one sub-module, block_addr_gen, containing the base mask, start offset, wrap counter and address output, shared by WB and FILL.

Verification (ADDR_W=16, WORD_BYTES=2, BLOCK_WORDS=8)
REQ-028 CWF=0, miss 0xFFF4, clean victim, mem_ready=1 -> reads issued at FFF0, FFF2, ..., FFFE on consecutive cycles; write_tag_array on the 8th valid; fsm_busy=0 the next cycle.
REQ-029 CWF=1, miss 0xFFF4 -> addresses FFF4, FFF6, ..., FFFE, FFF0, FFF2; data_word_idx sequence 2, 3, 4, 5, 6, 7, 0, 1.
REQ-030 Dirty victim 0x1230, miss 0x4566 -> 8 writes (mem_we=1) at 1230..123E with wb_word_idx 0..7, then reads at 4560..456E.
REQ-031 mem_ready=0 for 3 cycles when word 3 is issued (CWF=0, miss 0xFFF4) -> memory_address holds 0xFFF6 for 4 cycles, then the sequence resumes.
REQ-032 rst_n=0 after 4 valids -> IDLE next cycle, all outputs 0, no write_tag_array; the remaining 4 valids are ignored.
REQ-033 miss_detected=1, miss_address=0x0008 raised mid-fill -> ignored; the current fill addresses are unchanged.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and default parameters for the cache block fill/writeback controller.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_t;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_WORD_BYTES  = 2;
    localparam int DEF_BLOCK_WORDS = 8;
    localparam int DEF_CWF         = 0;

endpackage

// File: rtl/block_addr_gen.sv
// Block address generator: aligns an address to its block, applies an optional
// starting word offset and walks the block with a wrapping word counter.
module block_addr_gen
    import cache_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WORD_BYTES  = DEF_WORD_BYTES,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_W-1:0]              line_address,
    input  logic                           offset_en,
    input  logic                           clear,
    input  logic                           advance,
    output logic [$clog2(BLOCK_WORDS)-1:0] start_idx,
    output logic [$clog2(BLOCK_WORDS)-1:0] word_idx,
    output logic [$clog2(BLOCK_WORDS):0]   word_cnt,
    output logic [ADDR_W-1:0]              word_address
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam int OFF_W = $clog2(WORD_BYTES);
    localparam int BLK_W = $clog2(WORD_BYTES * BLOCK_WORDS);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << BLK_W) - 1);

    logic [CNT_W-1:0] word_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            word_cnt_reg <= '0;
        end else if (advance) begin
            word_cnt_reg <= word_cnt_reg + CNT_W'(1);
        end
    end

    // Index arithmetic is IDX_W wide, so the wrap around the block end is free.
    assign start_idx    = offset_en ? line_address[OFF_W +: IDX_W] : '0;
    assign word_idx     = start_idx + word_cnt_reg[IDX_W-1:0];
    assign word_cnt     = word_cnt_reg;
    assign word_address = (line_address & BASE_MASK) | (ADDR_W'(word_idx) << OFF_W);

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache miss controller: optional dirty-victim writeback followed by a block fill,
// with optional critical-word-first ordering.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WORD_BYTES  = DEF_WORD_BYTES,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int CWF         = DEF_CWF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_detected,
    input  logic [ADDR_W-1:0]              miss_address,
    input  logic                           victim_dirty,
    input  logic [ADDR_W-1:0]              victim_address,
    output logic                           fsm_busy,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              memory_address,
    input  logic                           mem_ready,
    input  logic                           memory_data_valid,
    output logic [$clog2(BLOCK_WORDS)-1:0] wb_word_idx,
    output logic [$clog2(BLOCK_WORDS)-1:0] data_word_idx,
    output logic                           write_data_array,
    output logic                           write_tag_array,
    output logic                           fill_done
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_WORDS);

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  miss_addr_reg, victim_addr_reg;
    logic               victim_dirty_reg;
    logic [CNT_W-1:0]   rsp_cnt_reg;

    logic [ADDR_W-1:0]  gen_line_addr, gen_word_addr;
    logic [IDX_W-1:0]   gen_start_idx, gen_word_idx;
    logic [CNT_W-1:0]   gen_word_cnt;
    logic               gen_offset_en, gen_clear, gen_advance;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miss_addr_reg    <= '0;
            victim_addr_reg  <= '0;
            victim_dirty_reg <= 1'b0;
        end else if (state_reg == IDLE && miss_detected) begin
            miss_addr_reg    <= miss_address;
            victim_addr_reg  <= victim_address;
            victim_dirty_reg <= victim_dirty;
        end
    end

    // Responses are counted on their own so a valid can coincide with an acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n || state_reg != FILL) begin
            rsp_cnt_reg <= '0;
        end else if (memory_data_valid) begin
            rsp_cnt_reg <= (rsp_cnt_reg == LAST_CNT) ? '0 : rsp_cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next       = state_reg;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        memory_address   = '0;
        wb_word_idx      = '0;
        data_word_idx    = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (miss_detected) begin
                    state_next = victim_dirty ? WB : FILL;
                end
            end
            WB: begin
                mem_req        = 1'b1;
                mem_we         = victim_dirty_reg;
                memory_address = gen_word_addr;
                wb_word_idx    = gen_word_idx;
                if (mem_ready && gen_word_cnt == LAST_CNT) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                mem_req          = (gen_word_cnt < FULL_CNT);
                memory_address   = gen_word_addr;
                data_word_idx    = gen_start_idx + rsp_cnt_reg[IDX_W-1:0];
                write_data_array = memory_data_valid;
                if (memory_data_valid && rsp_cnt_reg == LAST_CNT) begin
                    write_tag_array = 1'b1;
                    fill_done       = 1'b1;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign fsm_busy = (state_reg != IDLE);

    // One generator serves both phases; it restarts from word zero on every state change.
    assign gen_line_addr = (state_reg == WB) ? victim_addr_reg : miss_addr_reg;
    assign gen_offset_en = (CWF != 0) && (state_reg == FILL);
    assign gen_clear     = (state_next != state_reg);
    assign gen_advance   = mem_req && mem_ready;

    block_addr_gen #(
        .ADDR_W      (ADDR_W),
        .WORD_BYTES  (WORD_BYTES),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .line_address (gen_line_addr),
        .offset_en    (gen_offset_en),
        .clear        (gen_clear),
        .advance      (gen_advance),
        .start_idx    (gen_start_idx),
        .word_idx     (gen_word_idx),
        .word_cnt     (gen_word_cnt),
        .word_address (gen_word_addr)
    );

endmodule
